sysid_access_ctrl: RTL and testbench
====================================

# sysid_access_ctrl

Shares the single read-only system-ID slave between two Avalon-MM read masters. The block sits between the CPU data master (master 0), a debug/JTAG master (master 1) and the ID slave. It arbitrates round-robin and returns registered read data with a valid strobe. After reset it runs an optional boot check: it reads ID and timestamp, compares them against the expected build values, and holds off both masters until the check is done.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, system ID value expected at slave address 0
- EXPECTED_TS, 32'd1712826338, build timestamp expected at slave address 1

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_read  in  1  master 0 read request
- m0_address  in  1  master 0 word address (0 = ID, 1 = timestamp)
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  32  master 0 read data
- m0_readdatavalid  out  1  master 0 data strobe
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid  same as master 0, for master 1
- sid_address  out  1  address to the ID slave
- sid_readdata  in  32  combinational read data from the ID slave
- check_done  out  1  boot check finished
- id_ok  out  1  boot check passed
- id_mismatch  out  1  boot check failed

## Operation
- FSM states: CHK_ID, CHK_TS, SERVE. Reset enters CHK_ID, or SERVE if the check is compiled out.
- CHK_ID (1 cycle): sid_address=0; capture sid_readdata; compare with EXPECTED_ID; go to CHK_TS.
- CHK_TS (1 cycle): sid_address=1; compare with EXPECTED_TS; go to SERVE.
  - At the CHK_TS edge: check_done<=1; id_ok<=both equal; id_mismatch<=either differs.
  - These flags are sticky until the next reset.
- CHK_ID and CHK_TS: mN_waitrequest = mN_read. No read is accepted.
- SERVE: at most one read accepted per cycle.
  - Only one requester: it is granted.
  - Both request: grant the master not granted last. The last-grant pointer resets to master 1, so master 0 wins the first tie.
  - mN_waitrequest = mN_read & ~grantN, combinational.
  - A request held under waitrequest must keep its address stable (Avalon rule). The block does not check this.
- Accept cycle: sid_address = granted master's address. sid_readdata is registered into that master's readdata at the cycle's closing edge.
- Idle sid_address: 0 in SERVE.
- mN_readdata holds its last value until the next accept for that master.
- Mismatch does not block SERVE. Masters can still read the actual values.

## Timing
- Reset values: all waitrequest 0 (reads are 0 at reset); readdatavalid 0; readdata 0; check_done 0; id_ok 0; id_mismatch 0; pointer = master 1.
- Boot check completes 2 cycles after reset deassertion. The first accept is possible in the 3rd cycle.
- Read latency: fixed 1. readdatavalid is high for exactly 1 cycle, in the cycle after the accept.
- Throughput: 1 read per cycle total. Under continuous contention the grants alternate exactly.
- A master reading back-to-back, alone, gets a valid strobe every cycle.
- Reset asserted mid-transfer: the pending readdatavalid is dropped immediately. No strobe after release.
- A request that arrives during CHK_TS is accepted no earlier than the first SERVE cycle.

## Configuration
- SYSID_BOOTCHECK_EN defined:
  - CHK_ID and CHK_TS are present.
  - Flags behave as in Operation.
- SYSID_BOOTCHECK_EN undefined:
  - FSM reset state is SERVE; masters are served in the first cycle after reset.
  - check_done=1, id_ok=1, id_mismatch=0, held constant including during reset.
  - EXPECTED_ID and EXPECTED_TS are unused.

## Test plan
- Boot pass: slave returns 0 / 0x6617A7E2, defaults, macro on -> check_done=1, id_ok=1, id_mismatch=0 at cycle 2 after reset release; m0 read held from reset sees waitrequest=1 for cycles 0-1.
- Boot fail: slave returns 0x00000001 at address 0 -> id_mismatch=1, id_ok=0; a subsequent m0 read of address 0 returns 0x00000001.
- Contention: m0 reads address 0 and m1 reads address 1, continuously for 6 cycles -> grants m0,m1,m0,m1,m0,m1; each master gets 3 valid strobes with 0 and 0x6617A7E2 respectively.
- Single master streaming: m1 reads alternating addresses for 4 cycles -> 4 consecutive readdatavalid cycles, each 1 cycle after its accept, data 0,0x6617A7E2,0,0x6617A7E2.
- Reset mid-read: assert reset_n=0 in the accept cycle -> no readdatavalid ever appears for that read; all outputs at reset values.
- Macro off: m0 read in the first cycle after reset release -> accepted with waitrequest=0, valid next cycle; check_done=1, id_ok=1 throughout.

Source files
------------

// File: rtl/sysid_access_ctrl.sv
// sysid_access_ctrl: round-robin read arbiter in front of the single
// read-only system-ID slave, shared by two Avalon-MM read masters.
// Read data is registered, and readdatavalid follows the accept by one cycle.
// Optional boot check of ID/timestamp, enabled by defining SYSID_BOOTCHECK_EN.
// When that macro is undefined, the block serves from the first cycle after
// reset and the status flags are tied to "passed".
module sysid_access_ctrl #(
    parameter logic [31:0] EXPECTED_ID = 32'd0,
    parameter logic [31:0] EXPECTED_TS = 32'd1712826338
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_read,
    input  logic        m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_read,
    input  logic        m1_address,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        check_done,
    output logic        id_ok,
    output logic        id_mismatch
);

    localparam logic [1:0] CHK_ID = 2'd0;
    localparam logic [1:0] CHK_TS = 2'd1;
    localparam logic [1:0] SERVE  = 2'd2;

`ifdef SYSID_BOOTCHECK_EN
    localparam logic [1:0] RESET_STATE = CHK_ID;
`else
    localparam logic [1:0] RESET_STATE = SERVE;
`endif

    logic [1:0] state;
    logic [1:0] state_next;
    logic       serve;
    logic       grant0;
    logic       grant1;
    logic       last_m1;

    // Next state: the boot check runs once, then the block stays in SERVE
    always_comb begin
        state_next = SERVE;
        case (state)
            CHK_ID:  state_next = CHK_TS;
            CHK_TS:  state_next = SERVE;
            default: state_next = SERVE;
        endcase
    end

    // Grant: a lone requester wins, and on a tie the master not granted last wins
    always_comb begin
        serve  = (state == SERVE);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (serve) begin
            if (m0_read && m1_read) begin
                grant0 = last_m1;
                grant1 = ~last_m1;
            end else begin
                grant0 = m0_read;
                grant1 = m1_read;
            end
        end
    end

    assign m0_waitrequest = m0_read & ~grant0;
    assign m1_waitrequest = m1_read & ~grant1;

    // Slave address: the granted master's address, or the boot-check address otherwise
    always_comb begin
        if (grant0) begin
            sid_address = m0_address;
        end else if (grant1) begin
            sid_address = m1_address;
        end else begin
            sid_address = (state == CHK_TS);
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Round-robin pointer: remembers which master was granted last
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_m1 <= 1'b1;
        end else if (grant0) begin
            last_m1 <= 1'b0;
        end else if (grant1) begin
            last_m1 <= 1'b1;
        end
    end

    // Read return path: capture slave data for the granted master and strobe valid once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= grant0;
            m1_readdatavalid <= grant1;
            if (grant0) begin
                m0_readdata <= sid_readdata;
            end
            if (grant1) begin
                m1_readdata <= sid_readdata;
            end
        end
    end

`ifdef SYSID_BOOTCHECK_EN
    logic id_eq;

    // Boot check: compare the ID, then the timestamp, and latch the sticky result flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_eq       <= 1'b0;
            check_done  <= 1'b0;
            id_ok       <= 1'b0;
            id_mismatch <= 1'b0;
        end else begin
            if (state == CHK_ID) begin
                id_eq <= (sid_readdata == EXPECTED_ID);
            end
            if (state == CHK_TS) begin
                check_done  <= 1'b1;
                id_ok       <= id_eq && (sid_readdata == EXPECTED_TS);
                id_mismatch <= !(id_eq && (sid_readdata == EXPECTED_TS));
            end
        end
    end
`else
    assign check_done  = 1'b1;
    assign id_ok       = 1'b1;
    assign id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_access_ctrl.sv
// tb_sysid_access_ctrl: directed self-checking bench for sysid_access_ctrl.
// The boot-check scenarios run only when SYSID_BOOTCHECK_EN is defined.
module tb_sysid_access_ctrl;

    localparam logic [31:0] TS_VAL = 32'h6617A7E2;

`ifdef SYSID_BOOTCHECK_EN
    localparam logic RST_DONE = 1'b0;
    localparam logic RST_OK   = 1'b0;
`else
    localparam logic RST_DONE = 1'b1;
    localparam logic RST_OK   = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        m0_read, m0_address, m0_waitrequest, m0_readdatavalid;
    logic        m1_read, m1_address, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        sid_address;
    logic [31:0] sid_readdata;
    logic        check_done, id_ok, id_mismatch;
    logic [31:0] slave_id;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // ID slave model: combinational read of ID (address 0) or timestamp (address 1)
    assign sid_readdata = sid_address ? TS_VAL : slave_id;

    sysid_access_ctrl #(
        .EXPECTED_ID(32'd0),
        .EXPECTED_TS(32'd1712826338)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .m0_read         (m0_read),
        .m0_address      (m0_address),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read         (m1_read),
        .m1_address      (m1_address),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .sid_address     (sid_address),
        .sid_readdata    (sid_readdata),
        .check_done      (check_done),
        .id_ok           (id_ok),
        .id_mismatch     (id_mismatch)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n  = 1'b0;
        m0_read  = 1'b0;
        m1_read  = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    // Leaves the bench in the first SERVE cycle after a release
    task automatic skip_boot;
`ifdef SYSID_BOOTCHECK_EN
        step();
        step();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        logic exp_g0;

        reset_n    = 1'b0;
        m0_read    = 1'b0;
        m0_address = 1'b0;
        m1_read    = 1'b0;
        m1_address = 1'b0;
        slave_id   = 32'd0;

        // Reset values
        repeat (2) step();
        @(negedge clock);
        check("rst_m0_wait",  m0_waitrequest,   0);
        check("rst_m1_wait",  m1_waitrequest,   0);
        check("rst_m0_valid", m0_readdatavalid, 0);
        check("rst_m1_valid", m1_readdatavalid, 0);
        check("rst_m0_data",  m0_readdata,      0);
        check("rst_m1_data",  m1_readdata,      0);
        check("rst_done",     check_done,       RST_DONE);
        check("rst_ok",       id_ok,            RST_OK);
        check("rst_mis",      id_mismatch,      0);

        // m0 read held from release: stalls through the boot check, if present
        step();
        m0_read    = 1'b1;
        m0_address = 1'b1;
        reset_n    = 1'b1;
`ifdef SYSID_BOOTCHECK_EN
        @(negedge clock);
        check("boot_c0_wait", m0_waitrequest, 1);
        check("boot_c0_done", check_done,     0);
        step();
        @(negedge clock);
        check("boot_c1_wait", m0_waitrequest, 1);
        check("boot_c1_sid",  sid_address,    1);
        check("boot_c1_done", check_done,     0);
        step();
`endif
        @(negedge clock);
        check("first_wait", m0_waitrequest, 0);
        check("first_done", check_done,     1);
        check("first_ok",   id_ok,          1);
        check("first_mis",  id_mismatch,    0);
        step();
        m0_read = 1'b0;
        @(negedge clock);
        check("first_valid", m0_readdatavalid, 1);
        check("first_data",  m0_readdata,      TS_VAL);
        check("first_ok2",   id_ok,            1);
        step();
        @(negedge clock);
        check("first_valid_end", m0_readdatavalid, 0);

`ifdef SYSID_BOOTCHECK_EN
        // Boot fail: wrong ID, serving continues with the actual value
        slave_id = 32'h0000_0001;
        do_reset();
        skip_boot();
        m0_read    = 1'b1;
        m0_address = 1'b0;
        @(negedge clock);
        check("fail_done", check_done,     1);
        check("fail_ok",   id_ok,          0);
        check("fail_mis",  id_mismatch,    1);
        check("fail_wait", m0_waitrequest, 0);
        step();
        m0_read = 1'b0;
        @(negedge clock);
        check("fail_valid", m0_readdatavalid, 1);
        check("fail_data",  m0_readdata,      32'h0000_0001);
        check("fail_sticky", id_mismatch,     1);
        slave_id = 32'd0;
`endif

        // Contention: grants alternate, m0 wins the first tie
        do_reset();
        skip_boot();
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 6; i++) begin
            m0_read    = 1'b1;
            m0_address = 1'b0;
            m1_read    = 1'b1;
            m1_address = 1'b1;
            exp_g0     = (i % 2 == 0);
            @(negedge clock);
            check($sformatf("cont%0d_m0_wait", i), m0_waitrequest, !exp_g0);
            check($sformatf("cont%0d_m1_wait", i), m1_waitrequest, exp_g0);
            check($sformatf("cont%0d_sid", i),     sid_address,    !exp_g0);
            if (i > 0) begin
                check($sformatf("cont%0d_m0_valid", i), m0_readdatavalid, !exp_g0);
                check($sformatf("cont%0d_m1_valid", i), m1_readdatavalid, exp_g0);
            end
            if (m0_readdatavalid) begin
                n0++;
                check($sformatf("cont%0d_m0_data", i), m0_readdata, 0);
            end
            if (m1_readdatavalid) begin
                n1++;
                check($sformatf("cont%0d_m1_data", i), m1_readdata, TS_VAL);
            end
            step();
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        @(negedge clock);
        check("cont_tail_m0_valid", m0_readdatavalid, 0);
        check("cont_tail_m1_valid", m1_readdatavalid, 1);
        check("cont_tail_m1_data",  m1_readdata,      TS_VAL);
        if (m0_readdatavalid) n0++;
        if (m1_readdatavalid) n1++;
        check("cont_m0_strobes", n0, 3);
        check("cont_m1_strobes", n1, 3);
        step();

        // Single master streaming: m1 alone, alternating addresses
        for (int j = 0; j < 6; j++) begin
            m1_read    = (j < 4);
            m1_address = (j % 2 == 1);
            @(negedge clock);
            if (j < 4) check($sformatf("strm%0d_wait", j), m1_waitrequest, 0);
            check($sformatf("strm%0d_valid", j), m1_readdatavalid, (j >= 1 && j <= 4));
            check($sformatf("strm%0d_m0_valid", j), m0_readdatavalid, 0);
            if (j >= 1 && j <= 4)
                check($sformatf("strm%0d_data", j), m1_readdata, ((j - 1) % 2 == 1) ? TS_VAL : 32'd0);
            step();
        end

        // Reset asserted in the accept cycle: the strobe never appears
        m0_read    = 1'b1;
        m0_address = 1'b1;
        @(negedge clock);
        check("rmid_wait", m0_waitrequest, 0);
        #2;
        reset_n = 1'b0;
        m0_read = 1'b0;
        step();
        @(negedge clock);
        check("rmid_valid", m0_readdatavalid, 0);
        check("rmid_data",  m0_readdata,      0);
        check("rmid_done",  check_done,       RST_DONE);
        check("rmid_ok",    id_ok,            RST_OK);
        check("rmid_m1_data", m1_readdata,    0);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("rmid_post%0d_valid", k), m0_readdatavalid, 0);
            step();
        end

        // Reset asserted while a strobe is showing: it drops without a clock edge
        m0_read    = 1'b1;
        m0_address = 1'b1;
        step();
        m0_read = 1'b0;
        check("rasync_valid_pre", m0_readdatavalid, 1);
        check("rasync_data_pre",  m0_readdata,      TS_VAL);
        reset_n = 1'b0;
        #1;
        check("rasync_valid", m0_readdatavalid, 0);
        check("rasync_data",  m0_readdata,      0);
        #1;
        reset_n = 1'b1;
        step();
        @(negedge clock);
        check("rasync_post_valid", m0_readdatavalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
